// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int unsigned DEF_WIDTH    = 32;
  localparam int unsigned DEF_GROUP    = 4;
  localparam int unsigned PIPE_LATENCY = 3;

  // Group propagate/generate pair produced by one lookahead block
  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

endpackage

// File: rtl/cla_group_logic.sv
// One lookahead block: group P/G over N bits plus the carry into every bit.
// Used per bit-group and again as the second level over the groups.
module cla_group_logic
  import cla_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] p_i,
  input  logic [N-1:0] g_i,
  input  logic         c_i,
  output pg_t          pg_o,
  output logic [N-1:0] c_o
);

  // P/G never depend on c_i, so the two-level carry network has no loop
  always_comb begin : group_pg
    logic run_p;
    run_p  = 1'b1;
    pg_o   = '0;
    pg_o.p = &p_i;
    for (int j = 0; j < int'(N); j++) begin
      run_p = 1'b1;
      for (int m = j + 1; m < int'(N); m++) begin
        run_p &= p_i[m];
      end
      pg_o.g |= g_i[j] & run_p;
    end
  end

  // c_o[k] is the carry into bit k, expanded in flat lookahead form
  always_comb begin : group_carry
    logic acc;
    logic run_p;
    acc   = 1'b0;
    run_p = 1'b1;
    c_o   = '0;
    for (int k = 0; k < int'(N); k++) begin
      run_p = 1'b1;
      for (int m = 0; m < k; m++) begin
        run_p &= p_i[m];
      end
      acc = run_p & c_i;
      for (int j = 0; j < k; j++) begin
        run_p = 1'b1;
        for (int m = j + 1; m < k; m++) begin
          run_p &= p_i[m];
        end
        acc |= g_i[j] & run_p;
      end
      c_o[k] = acc;
    end
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Three-stage add/subtract with two-level carry lookahead and a
// valid/ready handshake that stalls the whole pipe when the output is held.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned GROUP = DEF_GROUP
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int unsigned NG = WIDTH / GROUP;

  if (WIDTH % GROUP != 0) begin : g_width_chk
    $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP");
  end
  if (GROUP != 2 && GROUP != 4 && GROUP != 8) begin : g_group_chk
    $error("pipelined_cla_adder: GROUP must be 2, 4 or 8");
  end
  if (WIDTH < 8 || WIDTH > 128) begin : g_range_chk
    $error("pipelined_cla_adder: WIDTH must be within 8..128");
  end

  logic                    adv;
  logic [PIPE_LATENCY-1:0] vld_q, vld_d;
  logic [WIDTH-1:0]        b_eff;

  logic [WIDTH-1:0] p1_q, p1_d;
  logic [WIDTH-1:0] g1_q, g1_d;
  logic             c1_q, c1_d;

  logic [WIDTH-1:0] p2_q, p2_d;
  logic [WIDTH:0]   c2_q, c2_d;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  pg_t              grp_pg [NG];
  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_cin;
  pg_t              top_pg;
  logic [WIDTH-1:0] bit_c;
  logic             carry_out;

  // Whole pipe moves together unless the held result is not being taken
  assign adv   = ~vld_q[PIPE_LATENCY-1] | out_ready_i;
  assign b_eff = b_i ^ {WIDTH{sub_i}};

  for (genvar gi = 0; gi < int'(NG); gi++) begin : g_grp
    cla_group_logic #(
      .N (GROUP)
    ) u_grp (
      .p_i  (p1_q[gi*GROUP +: GROUP]),
      .g_i  (g1_q[gi*GROUP +: GROUP]),
      .c_i  (grp_cin[gi]),
      .pg_o (grp_pg[gi]),
      .c_o  (bit_c[gi*GROUP +: GROUP])
    );
    assign grp_p[gi] = grp_pg[gi].p;
    assign grp_g[gi] = grp_pg[gi].g;
  end

  // Second level resolves every group carry-in directly from group P/G
  cla_group_logic #(
    .N (NG)
  ) u_lvl2 (
    .p_i  (grp_p),
    .g_i  (grp_g),
    .c_i  (c1_q),
    .pg_o (top_pg),
    .c_o  (grp_cin)
  );

  assign carry_out = top_pg.g | (top_pg.p & c1_q);

  always_comb begin : pipe_next
    vld_d  = vld_q;
    p1_d   = p1_q;
    g1_d   = g1_q;
    c1_d   = c1_q;
    p2_d   = p2_q;
    c2_d   = c2_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (adv) begin
      vld_d = {vld_q[PIPE_LATENCY-2:0], in_valid_i};
      if (in_valid_i) begin
        p1_d = a_i ^ b_eff;
        g1_d = a_i & b_eff;
        c1_d = sub_i | cin_i;
      end
      if (vld_q[0]) begin
        p2_d = p1_q;
        c2_d = {carry_out, bit_c};
      end
      if (vld_q[1]) begin
        sum_d  = p2_q ^ c2_q[WIDTH-1:0];
        cout_d = c2_q[WIDTH];
        ovf_d  = c2_q[WIDTH] ^ c2_q[WIDTH-1];
      end
    end
  end

  // Valid bits and the visible result are the only reset state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    p1_q <= p1_d;
    g1_q <= g1_d;
    c1_q <= c1_d;
    p2_q <= p2_d;
    c2_q <= c2_d;
  end

  assign in_ready_o  = adv;
  assign out_valid_o = vld_q[PIPE_LATENCY-1];
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: three widths driven in lockstep from one
// stimulus, checked against an arithmetic reference model and a scoreboard.
module tb_pipelined_cla_adder;
  import cla_pkg::*;

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic         cin;
    logic         sub;
  } op_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] a;
  logic [127:0] b;
  logic         cin;
  logic         sub;

  logic        rdy32, ov32, cout32, ovf32;
  logic [31:0] sum32;
  logic        rdy64, ov64, cout64, ovf64;
  logic [63:0] sum64;
  logic        rdy16, ov16, cout16, ovf16;
  logic [15:0] sum16;

  int       n_chk;
  int       n_err;
  int       n_out;
  op_t      sbq[$];
  logic     hold_prev;
  logic [120:0] prev_snap;
  vec_t     vt[8];
  op_t      sops[4];

  pipelined_cla_adder #(.WIDTH(32), .GROUP(4)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy32),
    .a_i(a[31:0]), .b_i(b[31:0]), .cin_i(cin), .sub_i(sub),
    .out_valid_o(ov32), .out_ready_i(out_ready),
    .sum_o(sum32), .cout_o(cout32), .ovf_o(ovf32)
  );

  pipelined_cla_adder #(.WIDTH(64), .GROUP(8)) u_dut64 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy64),
    .a_i(a[63:0]), .b_i(b[63:0]), .cin_i(cin), .sub_i(sub),
    .out_valid_o(ov64), .out_ready_i(out_ready),
    .sum_o(sum64), .cout_o(cout64), .ovf_o(ovf64)
  );

  pipelined_cla_adder #(.WIDTH(16), .GROUP(2)) u_dut16 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy16),
    .a_i(a[15:0]), .b_i(b[15:0]), .cin_i(cin), .sub_i(sub),
    .out_valid_o(ov16), .out_ready_i(out_ready),
    .sum_o(sum16), .cout_o(cout16), .ovf_o(ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, cout, sum} of a w-bit add/subtract using plain integers
  function automatic logic [129:0] ref_add(input int unsigned w, input op_t op);
    logic [128:0] mask, aa, bb, full, s;
    logic         co, ov;
    mask = (129'(1) << w) - 129'(1);
    aa   = {1'b0, op.a} & mask;
    bb   = {1'b0, (op.sub ? ~op.b : op.b)} & mask;
    full = aa + bb + 129'(op.sub ? 1'b1 : op.cin);
    s    = full & mask;
    co   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {ov, co, s[127:0]};
  endfunction

  function automatic op_t rand_op();
    op_t op;
    op.a   = {$urandom, $urandom, $urandom, $urandom};
    op.b   = {$urandom, $urandom, $urandom, $urandom};
    op.cin = 1'($urandom_range(0, 1));
    op.sub = 1'($urandom_range(0, 1));
    return op;
  endfunction

  function automatic logic [120:0] snap();
    return {ov32, ov64, ov16, sum32, cout32, ovf32, sum64, cout64, ovf64,
            sum16, cout16, ovf16};
  endfunction

  task automatic check(input string name, input logic [129:0] act, input logic [129:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_op(input string tag, input op_t op);
    check({tag, "_w32"}, {ovf32, cout32, 96'd0, sum32}, ref_add(32, op));
    check({tag, "_w64"}, {ovf64, cout64, 64'd0, sum64}, ref_add(64, op));
    check({tag, "_w16"}, {ovf16, cout16, 112'd0, sum16}, ref_add(16, op));
  endtask

  task automatic drive(input op_t op, input logic v);
    a        = op.a;
    b        = op.b;
    cin      = op.cin;
    sub      = op.sub;
    in_valid = v;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {127'd0, ov32, ov64, ov16}, 130'd0);
    check({tag, "_ready"}, {127'd0, rdy32, rdy64, rdy16}, {127'd0, 3'b111});
    check({tag, "_res"}, {9'd0, sum32, cout32, ovf32, sum64, cout64, ovf64, sum16, cout16, ovf16},
          130'd0);
  endtask

  initial begin
    op_t op;
    int  cnt;
    int  n0;

    n_chk = 0; n_err = 0; n_out = 0; hold_prev = 1'b0; prev_snap = '0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    vt[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vt[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vt[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vt[3] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vt[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vt[5] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0};
    vt[6] = '{32'h0000_000A, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
    vt[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

    fork
      // Scoreboard / protocol monitor, sampling on the falling edge
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          hold_prev = 1'b0;
        end else begin
          check("in_ready", {127'd0, rdy32, rdy64, rdy16},
                {127'd0, {3{~ov32 | out_ready}}});
          check("valid_agree", {128'd0, ov64, ov16}, {128'd0, ov32, ov32});
          if (hold_prev) check("hold", {9'd0, snap()}, {9'd0, prev_snap});
          hold_prev = ov32 && !out_ready;
          prev_snap = snap();
          if (ov32 && out_ready) begin
            if (sbq.size() == 0) begin
              check("unexpected_out", {129'd0, ov32}, 130'd0);
            end else begin
              op_t exp_op;
              exp_op = sbq.pop_front();
              check_op("sb", exp_op);
            end
            n_out++;
          end
          if (in_valid && rdy32) sbq.push_back('{a, b, cin, sub});
        end
      end
      forever begin
        @(negedge rst_n);
        sbq.delete();
      end
      begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed table: exact 3-cycle latency and known results
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      op = '{128'(vt[i].a), 128'(vt[i].b), vt[i].cin, vt[i].sub};
      drive(op, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < int'(PIPE_LATENCY); k++) begin
        @(negedge clk);
        check($sformatf("lat%0d_%0d", i, k), {129'd0, ov32},
              {129'd0, 1'(k == int'(PIPE_LATENCY) - 1)});
      end
      check($sformatf("vec%0d_w32", i), {ovf32, cout32, 96'd0, sum32},
            {vt[i].ovf, vt[i].cout, 96'd0, vt[i].sum});
      check_op($sformatf("vec%0d", i), op);
    end

    // Back-to-back stream: one result per cycle
    cnt = 0;
    n0  = n_out;
    for (int i = 0; i < 103; i++) begin
      @(posedge clk); #1;
      drive(rand_op(), 1'(i < 100));
      @(negedge clk);
      if (ov32) cnt++;
    end
    check("stream_count", 130'(cnt), 130'd100);
    check("stream_out", 130'(n_out - n0), 130'd100);

    // Full pipeline stalled for 5 cycles
    n0 = n_out;
    for (int i = 0; i < 4; i++) sops[i] = rand_op();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(sops[i], 1'b1);
    end
    @(posedge clk); #1;
    drive(sops[3], 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_ready", i), {127'd0, rdy32, rdy64, rdy16}, 130'd0);
      check($sformatf("stall%0d_valid", i), {129'd0, ov32}, 130'd1);
      check($sformatf("stall%0d_res", i), {ovf32, cout32, 96'd0, sum32}, ref_add(32, sops[0]));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("stall_out", 130'(n_out - n0), 130'd4);
    check("stall_empty", 130'(sbq.size()), 130'd0);

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(rand_op(), 1'b1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_valid", {129'd0, ov32}, 130'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0 = n_out;
    repeat (6) @(negedge clk);
    check("post_rst_quiet", 130'(n_out - n0), 130'd0);
    @(posedge clk); #1;
    drive(rand_op(), 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_one", 130'(n_out - n0), 130'd1);

    // Random bubbles and back-pressure
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      drive(rand_op(), 1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("drain_empty", 130'(sbq.size()), 130'd0);
    check("drain_idle", {129'd0, ov32}, 130'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand width; legal values are multiples of GROUP, 8..128.
REQ-002 SHALL provide parameter GROUP, default 4, lookahead group size; legal values are 2, 4 or 8.
REQ-003 SHALL provide port clk_i, input, 1 bit: the single clock; all flops are rising-edge.
REQ-004 SHALL provide port rst_ni, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL provide port in_valid_i, input, 1 bit: operands and controls are valid.
REQ-006 SHALL provide port in_ready_o, output, 1 bit: the block accepts operands this cycle.
REQ-007 SHALL provide port a_i, input, WIDTH bits: operand A.
REQ-008 SHALL provide port b_i, input, WIDTH bits: operand B.
REQ-009 SHALL provide port cin_i, input, 1 bit: carry-in; ignored when sub_i=1.
REQ-010 SHALL provide port sub_i, input, 1 bit: 1 selects A-B, 0 selects A+B+cin.
REQ-011 SHALL provide port out_valid_o, output, 1 bit: the result is valid.
REQ-012 SHALL provide port out_ready_i, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL provide port sum_o, output, WIDTH bits: result.
REQ-014 SHALL provide port cout_o, output, 1 bit: carry out of the MSB (inverted-B carry when subtracting).
REQ-015 SHALL provide port ovf_o, output, 1 bit: signed two's-complement overflow.

Function
REQ-016 SHALL compute in 3 register stages:
- S1 registers bitwise p=a^b' and g=a&b', where b'=b^{WIDTH{sub}}, plus effective cin = sub ? 1 : cin_i.
- S2 registers group P/G per GROUP bits, and all group carry-ins from a second-level lookahead over WIDTH/GROUP groups (two-level hierarchy, no ripple between groups).
- S3 registers sum=p^c, cout and ovf = c[WIDTH]^c[WIDTH-1].
REQ-017 SHALL deliver the result of an operand transfer (in_valid_i&in_ready_o) on out_valid_o exactly 3 cycles later when no stall occurs.
REQ-018 SHALL keep a valid bit in each stage; the pipeline advances when adv = !out_valid_o | out_ready_i.
REQ-019 SHALL drive in_ready_o = adv, combinationally; no combinational path from in_valid_i to in_ready_o.
REQ-020 SHALL hold sum_o, cout_o, ovf_o and out_valid_o stable while out_valid_o=1 and out_ready_i=0.
REQ-021 SHALL accept back-to-back transfers every cycle when out_ready_i is held 1, with throughput 1 result per cycle.
REQ-022 SHALL let a bubble (in_valid_i=0 on an advancing cycle) propagate as an invalid stage; bubbles are not squeezed out.
REQ-023 SHALL leave data flops of invalid stages don't-care; only valid bits are reset.
REQ-024 SHALL ignore in_valid_i with in_ready_o=0, and SHALL NOT capture the operands.
REQ-025 SHALL wrap arithmetic modulo 2^WIDTH, with overflow reported only via cout_o/ovf_o.

Reset
REQ-026 SHALL clear all stage valid bits asynchronously on rst_ni=0; out_valid_o=0, in_ready_o=1 during and after reset.
REQ-027 SHALL reset sum_o, cout_o and ovf_o to 0.
REQ-028 SHALL discard in-flight operations when reset asserts mid-operation; the first result after release comes from a post-reset transfer.

Structure
REQ-029 SHALL place shared constants in package cla_pkg: default WIDTH/GROUP, PIPE_LATENCY=3, and a typedef for the group P/G pair.
REQ-030 SHALL instantiate sub-module cla_group_logic, parametrised by N, once per group and once for the second level; it outputs group P, G and internal carries.
REQ-031 SHALL elaborate-time assert WIDTH % GROUP == 0.

Verification
REQ-032 Reset then A=0xFFFFFFFF, B=1, sub=0, cin=0 -> 3 cycles later sum=0, cout=1, ovf=0.
REQ-033 A=0x7FFFFFFF, B=1, sub=0 -> sum=0x80000000, cout=0, ovf=1; A=5, B=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
REQ-034 Stream 100 random ops with out_ready_i=1 -> one result per cycle, in order, matching the reference model.
REQ-035 Hold out_ready_i=0 for 5 cycles with a full pipeline -> in_ready_o=0, outputs frozen, and no op is lost or duplicated on release.
REQ-036 Assert rst_ni mid-stream with 3 ops in flight -> out_valid_o=0 immediately, no stale result after release.
REQ-037 Repeat REQ-032..REQ-035 for WIDTH=64, GROUP=8 and WIDTH=16, GROUP=2.
